// File: rtl/cnet_dma_rd_responder.sv
// cnet_dma_rd_responder: serves one receive-queue packet per CPCI DMA read request
// through an 8x32 buffer, preceded by a length word.
module cnet_dma_rd_responder (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dma_rd_request,
    input  logic [3:0]  dma_rd_mac,
    input  logic        dma_rd_en,
    output logic [31:0] dma_data,
    output logic        dma_empty,
    output logic        dma_nearly_empty,
    output logic        dma_all_in_buf,
    output logic        dma_rd_request_q_vld,
    output logic [3:0]  dma_rd_request_q,
    input  logic        dma_abort,
    input  logic [15:0] rxq_pkt_avail,
    output logic [3:0]  rxq_sel,
    input  logic [15:0] rxq_pkt_len,
    input  logic [31:0] rxq_data,
    input  logic        rxq_eop,
    input  logic        rxq_empty,
    output logic        rxq_rd_en,
    output logic        busy,
    output logic        len_mismatch
);
    typedef enum logic [2:0] {IDLE, LEN, XFER, DISCARD, DRAIN} state_t;
    state_t      state_q, state_d;
    logic [31:0] mem_q [8];
    logic [2:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [3:0]  count_q, count_d;
    logic [13:0] wcnt_q, wcnt_d, exp_q, exp_d;
    logic [3:0]  sel_q, sel_d, pq_q, pq_d;
    logic        vld_q, mism_q, mism_d;
    logic        push, do_push, pop, flush, full;
    logic [31:0] push_data;

    assign full    = count_q == 4'd8;
    assign do_push = push && !full;
    assign pop     = dma_rd_en && count_q != 4'd0 && !flush;

    always_comb begin
        pq_d = '0;
        for (int i = 15; i >= 0; i--)
            if (rxq_pkt_avail[i]) pq_d = 4'(i);
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        exp_d     = exp_q;
        wcnt_d    = wcnt_q;
        mism_d    = 1'b0;
        push      = 1'b0;
        push_data = rxq_data;
        flush     = 1'b0;
        rxq_rd_en = 1'b0;
        case (state_q)
            IDLE: if (dma_rd_request) begin
                sel_d   = dma_rd_mac;
                wcnt_d  = '0;
                state_d = LEN;
            end
            LEN: if (dma_abort) begin
                flush   = 1'b1;
                state_d = DISCARD;
            end else if (!full) begin
                push      = 1'b1;
                push_data = {16'h0, rxq_pkt_len};
                exp_d     = 14'((17'(rxq_pkt_len) + 17'd3) >> 2);
                // oversize and empty packets are consumed from the queue without buffering
                state_d   = (rxq_pkt_len[15:11] != 5'd0 || rxq_pkt_len == 16'd0) ? DISCARD : XFER;
            end
            XFER: if (dma_abort) begin
                flush   = 1'b1;
                state_d = DISCARD;
            end else begin
                rxq_rd_en = !full && !rxq_empty;
                if (rxq_rd_en) begin
                    push   = 1'b1;
                    wcnt_d = wcnt_q + 14'd1;
                    if (rxq_eop) begin
                        mism_d  = (wcnt_q + 14'd1) != exp_q;
                        state_d = DRAIN;
                    end
                end
            end
            DISCARD: begin
                rxq_rd_en = !rxq_empty;
                if (rxq_rd_en && rxq_eop) state_d = DRAIN;
            end
            DRAIN: if (dma_abort) begin
                flush   = 1'b1;
                state_d = IDLE;
            end else if (count_q == 4'd0) begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_ptr_d = flush ? 3'd0 : rd_ptr_q + 3'(pop);
        wr_ptr_d = flush ? 3'd0 : wr_ptr_q + 3'(do_push);
        count_d  = flush ? 4'd0 : count_q + 4'(do_push) - 4'(pop);
    end

    always_ff @(posedge clk)
        if (do_push) mem_q[wr_ptr_q] <= push_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wcnt_q   <= '0;
            exp_q    <= '0;
            sel_q    <= '0;
            mism_q   <= 1'b0;
            vld_q    <= 1'b0;
            pq_q     <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wcnt_q   <= wcnt_d;
            exp_q    <= exp_d;
            sel_q    <= sel_d;
            mism_q   <= mism_d;
            vld_q    <= |rxq_pkt_avail;
            pq_q     <= pq_d;
        end
    end

    assign dma_data             = mem_q[rd_ptr_q];
    assign dma_empty            = count_q == 4'd0;
    assign dma_nearly_empty     = count_q <= 4'd3;
    assign dma_all_in_buf       = state_q == DISCARD || state_q == DRAIN;
    assign dma_rd_request_q_vld = vld_q;
    assign dma_rd_request_q     = pq_q;
    assign rxq_sel              = sel_q;
    assign busy                 = state_q != IDLE;
    assign len_mismatch         = mism_q;
endmodule

// File: doc/cnet_dma_rd_responder.md
CNET_DMA_RD_RESPONDER -- requirements
Module: cnet_dma_rd_responder

Interface
REQ-001 Clock and reset are fixed: one clock, clk; reset_n is asynchronous and active-low.
REQ-002 Ports: clk in 1, rising-edge clock; reset_n in 1, asynchronous active-low reset.
REQ-003 CPCI side: dma_rd_request in 1, one-cycle start pulse; dma_rd_mac in 4, queue to serve, sampled with dma_rd_request; dma_rd_en in 1, pop one buffered word.
REQ-004 CPCI side outputs: dma_data out 32, buffer head word; dma_empty out 1; dma_nearly_empty out 1, 3 or fewer words buffered; dma_all_in_buf out 1, whole packet is buffered.
REQ-005 CPCI side outputs: dma_rd_request_q_vld out 1, some queue holds a packet; dma_rd_request_q out 4, lowest-index queue holding a packet.
REQ-006 CPCI side: dma_abort in 1, abort the transfer in progress.
REQ-007 Queue side: rxq_pkt_avail in 16, per-queue head-packet-present bit; rxq_sel out 4, selects the queue; rxq_pkt_len in 16, head packet byte length of the selected queue.
REQ-008 Queue side: rxq_data in 32, first-word-fall-through data; rxq_eop in 1, rxq_data is the last word; rxq_empty in 1; rxq_rd_en out 1, pop.
REQ-009 Status: busy out 1, state is not IDLE; len_mismatch out 1, one-cycle pulse.

Function
REQ-010 dma_rd_request_q_vld shall be |rxq_pkt_avail, registered.
REQ-011 dma_rd_request_q shall be the priority encode of rxq_pkt_avail (lowest index wins), registered.
REQ-012 The internal FIFO shall be 8 x 32.
- dma_empty: count==0.
- dma_nearly_empty: count<=3.
- full: count==8.
- dma_data shows the head word combinationally.
REQ-013 When dma_rd_en is high and the FIFO is empty, the pop shall be ignored and count shall not underflow.
REQ-014 Push and pop in the same cycle shall leave count unchanged; a push while full shall be blocked, not dropped.
REQ-015 States shall be IDLE, LEN, XFER, DISCARD, DRAIN.
REQ-016 IDLE: on dma_rd_request, latch dma_rd_mac into rxq_sel and go to LEN; requests outside IDLE shall be ignored.
REQ-017 LEN: one cycle; push {16'h0, rxq_pkt_len}.
- Expected words = ceil(len/4), computed in 14 bits.
- If rxq_pkt_len[15:11]!=0, go to DISCARD; else go to XFER.
REQ-018 XFER: rxq_rd_en = !full && !rxq_empty; each pop pushes rxq_data and increments a 14-bit word counter.
REQ-019 XFER: a pop with rxq_eop shall go to DRAIN.
- len_mismatch pulses if counter+1 != expected.
- No further words are popped past eop.
REQ-020 DISCARD: pop whenever !rxq_empty without pushing, until a word with rxq_eop is popped, then go to DRAIN.
REQ-021 DRAIN: dma_all_in_buf=1; return to IDLE the cycle after the FIFO becomes empty.
REQ-022 dma_all_in_buf shall also be 1 in DISCARD.
REQ-023 dma_abort in LEN or XFER shall go to DISCARD, flush the FIFO (count=0) and flush the remaining packet.
REQ-024 dma_abort in DISCARD shall be ignored; dma_abort in DRAIN shall flush the FIFO and go to IDLE.
REQ-025 A zero-length packet (len=0) shall push the length word only; the queue still pops its single eop word via DISCARD semantics.
REQ-026 rxq_rd_en shall never assert in IDLE, LEN or DRAIN.

Reset
REQ-027 While reset_n is low, all of the following shall hold:
- State = IDLE; FIFO count, pointers and word counter = 0.
- rxq_sel=0, rxq_rd_en=0, len_mismatch=0, busy=0.
- dma_empty=1, dma_nearly_empty=1, dma_all_in_buf=0.
- dma_rd_request_q_vld=0, dma_rd_request_q=0.
REQ-028 A reset asserted mid-transfer shall drop buffered words; the partial queue packet is not drained.

Verification
REQ-029 rxq_pkt_avail=16'h0014 -> after 1 cycle, q_vld=1 and request_q=2; request mac 2, len 10, 3 words with eop on the 3rd -> dma_data sequence 0x0000000A, w0, w1, w2; all_in_buf=1 after w2 is pushed; busy drops after the final pop.
REQ-030 len 64 (16 words), CPCI never pops -> rxq_rd_en stops with count=8 and 7 data words buffered; with dma_rd_en held high every cycle afterward, all 16 words arrive in order with no loss or duplication.
REQ-031 len 3000 -> length word 0x00000BB8 pushed; all queue words popped through eop with none pushed; state returns to IDLE once the length word is popped.
REQ-032 len 8, eop on word 3 -> len_mismatch pulses for one cycle; transfer ends after word 3.
REQ-033 dma_abort during XFER with 5 words buffered -> count=0 the next cycle; queue drained through eop; IDLE; a new request is then accepted normally.
REQ-034 reset_n low mid-XFER -> all outputs at reset values immediately (asynchronous), before the next clk edge.
